// File: rtl/prog_fetch_responder.sv
// ============================================================================
// prog_fetch_responder
// ----------------------------------------------------------------------------
// Program byte buffer that sits between a byte-serial program loader and a
// processor instruction-fetch port. The loader fills the buffer in order,
// starting at index 0. The processor fetches single bytes by address. A fetch
// of a byte that has not been loaded yet stalls, and HALT is raised until the
// byte arrives. A fetch beyond DEPTH completes at once with NOP_BYTE and an
// error flag.
//
// Handshakes:
//   load  : a byte transfers on a rising clk edge where ld_valid && ld_ready.
//           ld_data is written to mem[loaded_count], and loaded_count
//           increments. ld_ready is low once DEPTH bytes are held.
//   fetch : fetch_req is sampled only in IDLE, and fetch_addr is captured
//           then. Every accepted fetch ends with exactly one fetch_valid
//           pulse, even if fetch_req drops early. A reset aborts the fetch.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   ld_valid/ld_data  loader byte stream; ld_ready = buffer not full
//   fetch_req/addr    processor fetch request and 12-bit PC address
//   fetch_valid       one-cycle response strobe
//   fetch_data/err    response byte / out-of-range flag (held between pulses)
//   halt              high while a fetch waits for an unloaded byte
//   loaded_count      number of bytes loaded so far (0..DEPTH)
//   dbg_state         current FSM state (0 IDLE, 1 LOOKUP, 2 STALL, 3 RESPOND)
// ============================================================================
module prog_fetch_responder #(
    parameter int unsigned  DEPTH    = 16,
    parameter logic [7:0]   NOP_BYTE = 8'h00,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    input  logic          fetch_req,
    input  logic [11:0]   fetch_addr,
    output logic          fetch_valid,
    output logic [7:0]    fetch_data,
    output logic          fetch_err,
    output logic          halt,
    output logic [CW-1:0] loaded_count,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOOKUP  = 2'd1,
        S_STALL   = 2'd2,
        S_RESPOND = 2'd3
    } state_e;

    state_e        state_q, state_d;

    logic [7:0]    mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] count_eff;
    logic [11:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          err_q, err_d;

    logic          ld_fire;
    logic [31:0]   addr_wide;
    logic          addr_oor;
    logic          addr_avail;
    logic          fwd_hit;
    logic [7:0]    rd_byte;
    logic          resolve;

    // ------------------------------------------------------------------
    // Load side
    // ------------------------------------------------------------------
    assign ld_ready     = (count_q < CW'(DEPTH));
    assign ld_fire      = ld_valid && ld_ready;
    assign loaded_count = count_q;

    // Count as it will be after this edge. A lookup that uses this count
    // sees a byte that is being loaded in the same cycle.
    assign count_eff = count_q + {{(CW-1){1'b0}}, ld_fire};

    always_comb begin
        count_d = count_q;
        if (ld_fire) begin
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Storage has no reset. Stale contents cannot be read because
    // loaded_count restarts at zero.
    always_ff @(posedge clk) begin
        if (ld_fire && !rst) begin
            mem_q[count_q[AW-1:0]] <= ld_data;
        end
    end

    // ------------------------------------------------------------------
    // Address decode against the captured fetch address
    // ------------------------------------------------------------------
    assign addr_wide  = {20'd0, addr_q};
    assign addr_oor   = (addr_wide >= DEPTH);
    assign addr_avail = (addr_wide < {{(32-CW){1'b0}}, count_eff});

    // The byte being written right now is the one we want. Forward it
    // straight from ld_data, because the array write only lands at the edge.
    assign fwd_hit = ld_fire && (addr_wide == {{(32-CW){1'b0}}, count_q});
    assign rd_byte = fwd_hit ? ld_data : mem_q[addr_q[AW-1:0]];

    always_comb begin
        addr_d = addr_q;
        if ((state_q == S_IDLE) && fetch_req) begin
            addr_d = fetch_addr;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_req) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (addr_oor || addr_avail) begin
                    state_d = S_RESPOND;
                end else begin
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                // The address is known to be in range here, so only
                // arrival of the byte matters.
                if (addr_avail) begin
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // fetch_valid and halt are decoded from the registered state only, so
    // they cannot glitch when the state changes. The response byte is
    // registered on the edge that enters RESPOND. It then holds until the
    // next response or a reset.
    always_comb begin
        resolve = ((state_q == S_LOOKUP) || (state_q == S_STALL)) &&
                  (state_d == S_RESPOND);
        data_d  = data_q;
        err_d   = err_q;
        if (resolve) begin
            data_d = addr_oor ? NOP_BYTE : rd_byte;
            err_d  = addr_oor;
        end
    end

    assign fetch_valid = (state_q == S_RESPOND);
    assign halt        = (state_q == S_STALL);
    assign dbg_state   = state_q;
    assign fetch_data  = data_q;
    assign fetch_err   = err_q;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_prog_fetch_responder.sv
module tb_prog_fetch_responder;

    localparam int DEPTH = 16;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic        clk;
    logic        rst;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        fetch_req;
    logic [11:0] fetch_addr;
    logic        fetch_valid;
    logic [7:0]  fetch_data;
    logic        fetch_err;
    logic        halt;
    logic [4:0]  loaded_count;
    logic [1:0]  dbg_state;

    prog_fetch_responder dut (
        .clk          (clk),
        .rst          (rst),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_valid  (fetch_valid),
        .fetch_data   (fetch_data),
        .fetch_err    (fetch_err),
        .halt         (halt),
        .loaded_count (loaded_count),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard counters and check helper
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, dbg_state=%0d)",
                     nm, act, exp, $time, dbg_state);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no fetch_valid within cycle budget (t=%0t)", nm, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. It works on a timeline of clock edges, not on FSM
    // states. A fetch accepted at edge s is answered at the first edge
    // after s where the address is out of range or the byte has been
    // loaded (a load on that same edge counts). The next fetch can be
    // accepted two edges after the answer. halt is expected on every edge
    // after s until the answer arrives.
    // ------------------------------------------------------------------
    int          k = 0;
    bit          m_ok = 0;
    logic [7:0]  m_mem [DEPTH];
    int          m_count = 0;
    bit          m_pend = 0;
    int          m_s = 0;
    logic [11:0] m_addr = '0;
    int          m_next_free = 0;
    int          m_resp_edge = -1;
    logic [7:0]  m_data = 8'h00;
    logic        m_err = 1'b0;

    task automatic m_respond(input logic [7:0] d, input logic e);
        m_pend      = 0;
        m_resp_edge = k;
        m_data      = d;
        m_err       = e;
        m_next_free = k + 2;
    endtask

    task automatic model_step();
        k++;
        if (rst) begin
            m_ok        = 1;
            m_count     = 0;
            m_pend      = 0;
            m_next_free = k + 1;
            m_resp_edge = -1;
            m_data      = 8'h00;
            m_err       = 1'b0;
            return;
        end
        if (ld_valid && m_count < DEPTH) begin
            m_mem[m_count] = ld_data;
            m_count++;
        end
        if (m_pend) begin
            if (k > m_s) begin
                if (int'(m_addr) >= DEPTH)        m_respond(8'h00, 1'b1);
                else if (int'(m_addr) < m_count)  m_respond(m_mem[m_addr], 1'b0);
            end
        end else if (k >= m_next_free && fetch_req) begin
            m_pend = 1;
            m_s    = k;
            m_addr = fetch_addr;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: outputs are checked half a cycle after each edge.
    initial forever begin
        @(negedge clk);
        if (m_ok) begin
            check("ld_ready",     16'(ld_ready),     16'(m_count < DEPTH));
            check("loaded_count", 16'(loaded_count), 16'(m_count));
            check("halt",         16'(halt),         16'(m_pend && (k > m_s)));
            check("fetch_valid",  16'(fetch_valid),  16'(k == m_resp_edge));
            check("fetch_data",   16'(fetch_data),   16'(m_data));
            check("fetch_err",    16'(fetch_err),    16'(m_err));
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks. Inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_data  = b;
        step(1);
        ld_valid = 1'b0;
    endtask

    task automatic do_fetch(input logic [11:0] a, input logic [7:0] ed, input logic ee,
                            input int exp_lat, input string nm);
        bit got = 0;
        int lat = 0;
        fetch_req  = 1'b1;
        fetch_addr = a;
        for (int i = 1; i <= 40 && !got; i++) begin
            step(1);
            if (fetch_valid) begin
                got = 1;
                lat = i;
            end
        end
        fetch_req = 1'b0;
        if (!got) begin
            timeout(nm);
        end else begin
            check({nm, "_lat"},  16'(lat),        16'(exp_lat));
            check({nm, "_data"}, 16'(fetch_data), 16'(ed));
            check({nm, "_err"},  16'(fetch_err),  16'(ee));
        end
        step(1);
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int pulses;
        rst        = 1'b1;
        ld_valid   = 1'b0;
        ld_data    = 8'h00;
        fetch_req  = 1'b0;
        fetch_addr = 12'h000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_count",  16'(loaded_count), 16'd0);
        check("rst_ready",  16'(ld_ready),     16'd1);
        check("rst_valid",  16'(fetch_valid),  16'd0);
        check("rst_data",   16'(fetch_data),   16'h00);
        check("rst_err",    16'(fetch_err),    16'd0);
        check("rst_halt",   16'(halt),         16'd0);

        // Load four bytes, then fetch addr 2: minimum latency and no halt
        load_byte(8'hA1);
        load_byte(8'hB2);
        load_byte(8'hC3);
        load_byte(8'hD4);
        check("four_count", 16'(loaded_count), 16'd4);
        do_fetch(12'd2, 8'hC3, 1'b0, 2, "fetch2");
        do_fetch(12'd0, 8'hA1, 1'b0, 2, "fetch0");

        // Out-of-range fetch with an almost empty buffer: no stall
        do_fetch(12'h010, 8'h00, 1'b1, 2, "oor_early");

        // Fill to DEPTH; the 17th byte must be ignored
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            load_byte(8'(8'h40 + i));
        end
        check("full_ready", 16'(ld_ready),     16'd0);
        check("full_count", 16'(loaded_count), 16'd16);
        load_byte(8'hEE);
        check("sat_count",  16'(loaded_count), 16'd16);
        do_fetch(12'd0,   8'h40, 1'b0, 2, "mem0_kept");
        do_fetch(12'd15,  8'h4F, 1'b0, 2, "mem15");
        do_fetch(12'h010, 8'h00, 1'b1, 2, "oor16");
        do_fetch(12'hFFF, 8'h00, 1'b1, 2, "oorfff");

        // fetch_req held high: a new fetch every third cycle
        pulses     = 0;
        fetch_req  = 1'b1;
        fetch_addr = 12'd7;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (fetch_valid) pulses++;
        end
        fetch_req = 1'b0;
        check("b2b_pulses", 16'(pulses), 16'd3);
        step(2);

        // Stall on addr 5 with fetch_req dropped early; forwarded byte
        do_reset();
        load_byte(8'h11);
        load_byte(8'h22);
        fetch_req  = 1'b1;
        fetch_addr = 12'd5;
        step(1);
        fetch_req = 1'b0;
        check("lookup_halt", 16'(halt), 16'd0);
        step(1);
        check("stall_halt",  16'(halt), 16'd1);
        load_byte(8'h33);
        load_byte(8'h44);
        load_byte(8'h55);
        check("stall_hold",  16'(halt), 16'd1);
        ld_valid = 1'b1;
        ld_data  = 8'h7E;
        step(1);
        ld_valid = 1'b0;
        check("fwd_valid",   16'(fetch_valid), 16'd1);
        check("fwd_data",    16'(fetch_data),  16'h7E);
        check("fwd_halt",    16'(halt),        16'd0);
        step(2);
        check("fwd_holddat", 16'(fetch_data),  16'h7E);

        // Reset in the middle of a stall aborts the fetch
        do_reset();
        load_byte(8'h01);
        load_byte(8'h02);
        load_byte(8'h03);
        fetch_req  = 1'b1;
        fetch_addr = 12'd3;
        step(1);
        fetch_req = 1'b0;
        step(1);
        check("abort_pre",   16'(halt), 16'd1);
        do_reset();
        check("abort_halt",  16'(halt),         16'd0);
        check("abort_count", 16'(loaded_count), 16'd0);
        check("abort_valid", 16'(fetch_valid),  16'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (fetch_valid) pulses++;
        end
        check("abort_nopulse", 16'(pulses), 16'd0);

        // Same-cycle load and lookup of addr 0
        do_reset();
        fetch_req  = 1'b1;
        fetch_addr = 12'd0;
        step(1);
        fetch_req = 1'b0;
        ld_valid  = 1'b1;
        ld_data   = 8'h5A;
        step(1);
        ld_valid = 1'b0;
        check("same_valid", 16'(fetch_valid), 16'd1);
        check("same_data",  16'(fetch_data),  16'h5A);
        check("same_err",   16'(fetch_err),   16'd0);
        check("same_halt",  16'(halt),        16'd0);
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_fetch_responder.md
PROG_FETCH_RESPONDER -- requirements
Module: prog_fetch_responder

Interface
REQ-001 Parameter DEPTH, default 16, number of 8-bit program bytes held (power of two, 2..256).
REQ-002 Parameter NOP_BYTE, default 8'h00, byte returned for out-of-range fetches.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset; sampled on rising clk.
REQ-005 ld_valid  input  1  loader presents a program byte.
REQ-006 ld_data  input  8  program byte, written at next free index.
REQ-007 ld_ready  output  1  buffer can accept a byte this cycle.
REQ-008 fetch_req  input  1  processor requests an instruction byte; held until fetch_valid.
REQ-009 fetch_addr  input  12  program-counter address of requested byte; stable while fetch_req high.
REQ-010 fetch_valid  output  1  one-cycle pulse, fetch_data valid.
REQ-011 fetch_data  output  8  returned instruction byte.
REQ-012 fetch_err  output  1  qualifies fetch_valid: address outside DEPTH.
REQ-013 halt  output  1  processor HALT request; high while a fetch is stalled on unloaded data.
REQ-014 loaded_count  output  log2(DEPTH)+1  bytes loaded so far.

Function
REQ-015 Load handshake: byte accepted when ld_valid and ld_ready both high at rising clk; written to mem[loaded_count], loaded_count increments by 1.
REQ-016 ld_ready = (loaded_count < DEPTH); at DEPTH no further writes, count saturates, no wrap.
REQ-017 FSM states IDLE, LOOKUP, STALL, RESPOND; one-hot or binary, implementer's choice.
REQ-018 IDLE: fetch_req high -> LOOKUP, fetch_addr captured into internal address register.
REQ-019 LOOKUP: captured addr >= DEPTH -> RESPOND with fetch_data=NOP_BYTE, fetch_err=1.
REQ-020 LOOKUP: addr < loaded_count (after any same-cycle load) -> RESPOND with fetch_data=mem[addr], fetch_err=0.
REQ-021 LOOKUP: addr < DEPTH and addr >= loaded_count -> STALL.
REQ-022 STALL: halt=1; remains until loaded_count > addr, then RESPOND with mem[addr].
REQ-023 Byte written in cycle N to the stalled address is returned by RESPOND in cycle N+1 (write-through forwarding, no extra cycle).
REQ-024 RESPOND: fetch_valid=1 for exactly one cycle, fetch_data/fetch_err valid that cycle; next state IDLE.
REQ-025 Minimum latency fetch_req rise -> fetch_valid: 2 cycles (IDLE->LOOKUP->RESPOND); back-to-back fetches need fetch_req high again in IDLE, giving 3-cycle throughput.
REQ-026 fetch_data, fetch_err hold last values outside RESPOND; fetch_valid=0 outside RESPOND.
REQ-027 halt=0 in every state except STALL; halt combinational from state, no glitch at state change.
REQ-028 Loading continues in every FSM state; fetch and load never block each other.
REQ-029 fetch_req dropped in LOOKUP or STALL: transaction still completes with fetch_valid pulse.

Reset
REQ-030 rst high at clk edge: state IDLE, loaded_count=0, ld_ready=1 (next cycle), fetch_valid=0, fetch_data=8'h00, fetch_err=0, halt=0.
REQ-031 Memory contents not cleared by reset; unreadable until reloaded since loaded_count=0.
REQ-032 Reset mid-STALL or mid-RESPOND aborts the fetch: no fetch_valid pulse follows, halt drops the cycle after reset.

Verification
REQ-033 Load 4 bytes 8'hA1,8'hB2,8'hC3,8'hD4; fetch addr 2 -> fetch_valid 2 cycles later, fetch_data=8'hC3, fetch_err=0, halt never high.
REQ-034 Load 16 bytes; ld_ready low after 16th; 17th ld_valid ignored, loaded_count=16, mem[0] unchanged.
REQ-035 Fetch addr 12'h010 with DEPTH=16 -> fetch_valid, fetch_data=8'h00, fetch_err=1.
REQ-036 Load 2 bytes, fetch addr 5 -> halt=1 from cycle after LOOKUP; load bytes 2..5 (5th = 8'h7E) -> halt low and fetch_valid with 8'h7E the cycle after the addr-5 write.
REQ-037 Stall on addr 3, assert rst -> halt=0, no fetch_valid, loaded_count=0.
REQ-038 Load byte to addr 0 in same cycle LOOKUP evaluates fetch addr 0 -> no stall, fetch_data equals newly loaded byte.
